// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// Ports: clk, reset (sync, active-high); Start/MDOp/A/B launch;
//   MTHI/MTLO move A into HI/LO; Busy, HI, LO are registered outputs.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MTHI,
  input  logic        MTLO,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [31:0] MULT_LD = 32'(MULT_CYCLES - 1);
  localparam logic [31:0] DIV_LD  = 32'(DIV_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_q;
  logic [31:0]        w_r;
  logic               w_dz;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a})
                  * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide on magnitudes; 0x80000000 / -1 then
  // wraps naturally to 0x80000000 with remainder 0.
  assign w_a_neg = r_a[31] & ~r_op[0];
  assign w_b_neg = r_b[31] & ~r_op[0];
  assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0
                 : w_a_mag / w_b_mag;
  assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0
                 : w_a_mag % w_b_mag;
  assign w_q = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag)
             : w_q_mag;
  assign w_r = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_dz = r_op[1] & (r_b == 32'd0);

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    unique case (r_op)
      2'b00: {w_res_hi, w_res_lo} = w_prod_s;
      2'b01: {w_res_hi, w_res_lo} = w_prod_u;
      default: begin
        w_res_hi = w_r;
        w_res_lo = w_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 2'd0;
      Busy    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= MDOp;
            r_cnt   <= MDOp[1] ? DIV_LD : MULT_LD;
            r_state <= S_RUN;
            Busy    <= 1'b1;
          end else begin
            if (MTHI) HI <= A;
            if (MTLO) LO <= A;
          end
        end
        S_RUN: begin
          if (r_cnt == 32'd0) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
            if (!w_dz) begin
              HI <= w_res_hi;
              LO <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, Busy duration in cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, Busy duration in cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle launch pulse from the E stage, qualified by MDOp.
REQ-006 SHALL have port MDOp  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port A  input  32  rs operand (multiplicand or dividend).
REQ-008 SHALL have port B  input  32  rt operand (multiplier or divisor).
REQ-009 SHALL have port MTHI  input  1  write A into HI (mthi).
REQ-010 SHALL have port MTLO  input  1  write A into LO (mtlo).
REQ-011 SHALL have port Busy  output  1  operation in progress; consumed by the hazard unit to stall mult/mt/mf instructions in D.
REQ-012 SHALL have port HI  output  32  registered HI value.
REQ-013 SHALL have port LO  output  32  registered LO value.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (Busy=0) and RUN (Busy=1).
REQ-015 In IDLE, a Start sampled high at edge k SHALL latch A, B and MDOp, load the cycle counter, and enter RUN; Busy SHALL be 1 from edge k until edge k+N, where N=MULT_CYCLES for MDOp[1]=0 and N=DIV_CYCLES for MDOp[1]=1.
REQ-016 Busy SHALL be high for exactly N consecutive cycles after the launch edge; on edge k+N, HI/LO SHALL be written with the result and the FSM SHALL return to IDLE.
REQ-017 HI/LO SHALL NOT change during RUN; they SHALL hold their pre-launch values until edge k+N.
REQ-018 mult: {HI,LO} SHALL equal the signed 64-bit product of the latched A and B.
REQ-019 multu: {HI,LO} SHALL equal the unsigned 64-bit product.
REQ-020 div: LO SHALL be the signed quotient truncated toward zero; HI SHALL be the remainder, carrying the sign of the dividend.
REQ-021 divu: LO SHALL be the unsigned quotient; HI SHALL be the unsigned remainder.
REQ-022 Divide by zero (B=0, div or divu): the full DIV_CYCLES Busy window SHALL still run; HI and LO SHALL remain unchanged at completion.
REQ-023 div with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-024 Start sampled during RUN SHALL be ignored; the operation in flight, its counter and its latched operands SHALL be unaffected.
REQ-025 MTHI/MTLO in IDLE with Start low SHALL write A into HI/LO at that edge; both asserted together SHALL write A into both registers.
REQ-026 MTHI/MTLO during RUN SHALL be ignored.
REQ-027 Start and MTHI/MTLO in the same IDLE cycle: Start SHALL take priority and the move SHALL be ignored.
REQ-028 The unit SHALL return to IDLE with Busy=0 on edge k+N; a new Start at edge k+N is therefore not accepted, and the earliest accepted Start is at edge k+N+1.
REQ-029 Operands SHALL be sampled only at the launch edge; later changes on A, B or MDOp SHALL NOT affect the result.

Reset
REQ-030 With reset high at an edge, the unit SHALL set the FSM to IDLE, Busy=0, HI=0, LO=0 and counter=0, overriding Start, MTHI and MTLO in the same cycle.
REQ-031 Reset during RUN SHALL discard the pending result; HI/LO SHALL read 0 afterwards and SHALL never take the discarded value.

Verification
REQ-032 mult with A=0xFFFFFFFF, B=0x00000002 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-033 multu with A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
REQ-034 div with A=0xFFFFFFF9 (-7), B=0x00000002 -> Busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 and HI/LO preloaded to 0x11111111/0x22222222 via MTHI/MTLO -> both unchanged after 10 cycles.
REQ-035 div launch, then a second Start (mult, different operands) in Busy cycle 3 -> second Start ignored; Busy falls after 10 cycles total; div result only.
REQ-036 MTHI with A=0x12345678 in cycle 2 of a mult -> ignored; MTLO in IDLE with A=0xCAFEBABE -> LO=0xCAFEBABE on the next edge.
REQ-037 Reset in Busy cycle 3 of a mult with A=3, B=4 -> Busy=0, HI=LO=0 on the next edge; no later write of 12 occurs.
